// File: rtl/muxn_pkg.sv
// Shared constants and helpers for the N-input pipelined select stage.
package muxn_pkg;

    // Select encodings
    localparam int SEL_BINARY = 0;
    localparam int SEL_ONEHOT = 1;

    // Illegal-select counter geometry
    localparam int             ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Width of the select bus for a given input count and encoding
    function automatic int sel_w(input int n_in, input int mode);
        if (mode == SEL_ONEHOT) begin
            return n_in;
        end
        return $clog2(n_in);
    endfunction

endpackage

// File: rtl/muxn_sel_decode.sv
// Combinational select decoder: turns a binary index or one-hot vector
// into a one-hot grant and flags encodings that name no valid input.
module muxn_sel_decode
    import muxn_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int SEL_MODE = SEL_BINARY,
    localparam int SW      = sel_w(N_IN, SEL_MODE)
) (
    input  logic [SW-1:0]   i_sel,
    output logic [N_IN-1:0] o_grant,
    output logic            o_illegal
);

    generate
        if (SEL_MODE == SEL_ONEHOT) begin : g_onehot
            // The vector already is the grant; only exactly one bit set is usable
            assign o_grant   = i_sel;
            assign o_illegal = !$onehot(i_sel);
        end else begin : g_binary
            genvar gi;
            for (gi = 0; gi < N_IN; gi++) begin : g_grant
                assign o_grant[gi] = (i_sel == SW'(gi));
            end
            // With a power-of-two input count every index is populated
            if (N_IN == (1 << SW)) begin : g_full
                assign o_illegal = 1'b0;
            end else begin : g_partial
                assign o_illegal = ({1'b0, i_sel} >= (SW+1)'(N_IN));
            end
        end
    endgenerate

endmodule

// File: rtl/muxn_pipe.sv
// N-input multiplexer followed by a pipeline register with valid, stall,
// flush, illegal-select substitution and a saturating illegal-select count.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int            NB          = 32,
    parameter int            N_IN        = 4,
    parameter int            SEL_MODE    = SEL_BINARY,
    parameter logic [NB-1:0] DEFAULT_VAL = '0,
    localparam int           SW          = sel_w(N_IN, SEL_MODE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [SW-1:0]        i_sel,
    input  logic [N_IN*NB-1:0]   i_data,
    output logic [NB-1:0]        o_data,
    output logic                 o_valid,
    output logic                 o_sel_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    logic [N_IN-1:0]      w_grant;
    logic                 w_illegal;
    logic [NB-1:0]        w_masked [N_IN];
    logic [NB-1:0]        w_sel_data;
    logic [NB-1:0]        w_next_data;

    logic [NB-1:0]        r_data;
    logic                 r_valid;
    logic                 r_sel_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    muxn_sel_decode #(
        .N_IN     (N_IN),
        .SEL_MODE (SEL_MODE)
    ) u_decode (
        .i_sel     (i_sel),
        .o_grant   (w_grant),
        .o_illegal (w_illegal)
    );

    // Gate each input word by its grant bit
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_mask
            assign w_masked[gi] = {NB{w_grant[gi]}} & i_data[gi*NB +: NB];
        end
    endgenerate

    // OR-reduce the gated words; illegal selects fall back to the default word
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_sel_data = w_sel_data | w_masked[k];
        end
        w_next_data = w_illegal ? DEFAULT_VAL : w_sel_data;
    end

    // Pipeline register: flush beats stall beats load; counter only moves on accepted illegal words
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (i_flush) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
        end else if (!i_stall) begin
            if (i_valid) begin
                r_data    <= w_next_data;
                r_valid   <= 1'b1;
                r_sel_err <= w_illegal;
                if (w_illegal && (r_err_cnt != ERR_CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else begin
                r_valid   <= 1'b0;
                r_sel_err <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_sel_err = r_sel_err;
    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_muxn_pipe.sv
// Directed bench for muxn_pipe: three instances cover binary power-of-two,
// binary non-power-of-two and one-hot configurations.
module tb_muxn_pipe;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // binary, N_IN=4
    logic         b4_valid, b4_stall, b4_flush;
    logic [1:0]   b4_sel;
    logic [127:0] b4_data;
    logic [31:0]  b4_q;
    logic         b4_v, b4_e;
    logic [7:0]   b4_c;
    // binary, N_IN=3, default 0xDEAD
    logic         b3_valid, b3_stall, b3_flush;
    logic [1:0]   b3_sel;
    logic [95:0]  b3_data;
    logic [31:0]  b3_q;
    logic         b3_v, b3_e;
    logic [7:0]   b3_c;
    // one-hot, N_IN=4, default 0xBEEF
    logic         oh_valid, oh_stall, oh_flush;
    logic [3:0]   oh_sel;
    logic [127:0] oh_data;
    logic [31:0]  oh_q;
    logic         oh_v, oh_e;
    logic [7:0]   oh_c;

    muxn_pipe #(.NB(32), .N_IN(4), .SEL_MODE(0), .DEFAULT_VAL(32'h0000_DEAD)) u_b4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b4_valid), .i_stall(b4_stall),
        .i_flush(b4_flush), .i_sel(b4_sel), .i_data(b4_data),
        .o_data(b4_q), .o_valid(b4_v), .o_sel_err(b4_e), .o_err_cnt(b4_c));

    muxn_pipe #(.NB(32), .N_IN(3), .SEL_MODE(0), .DEFAULT_VAL(32'h0000_DEAD)) u_b3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b3_valid), .i_stall(b3_stall),
        .i_flush(b3_flush), .i_sel(b3_sel), .i_data(b3_data),
        .o_data(b3_q), .o_valid(b3_v), .o_sel_err(b3_e), .o_err_cnt(b3_c));

    muxn_pipe #(.NB(32), .N_IN(4), .SEL_MODE(1), .DEFAULT_VAL(32'h0000_BEEF)) u_oh (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(oh_valid), .i_stall(oh_stall),
        .i_flush(oh_flush), .i_sel(oh_sel), .i_data(oh_data),
        .o_data(oh_q), .o_valid(oh_v), .o_sel_err(oh_e), .o_err_cnt(oh_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick(input bit verbose);
        @(posedge clk);
        #1;
        if (verbose)
            $display("t=%0t b4 q=%h v=%b e=%b c=%0d | b3 q=%h v=%b e=%b c=%0d | oh q=%h v=%b e=%b c=%0d",
                     $time, b4_q, b4_v, b4_e, b4_c, b3_q, b3_v, b3_e, b3_c, oh_q, oh_v, oh_e, oh_c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b4_valid = 0; b4_stall = 0; b4_flush = 0; b4_sel = 0;
        b3_valid = 0; b3_stall = 0; b3_flush = 0; b3_sel = 0;
        oh_valid = 0; oh_stall = 0; oh_flush = 0; oh_sel = 0;
        b4_data = {32'h33, 32'h22, 32'h11, 32'h00};
        b3_data = {32'h22, 32'h11, 32'h00};
        oh_data = {32'h33, 32'h22, 32'h11, 32'h00};
        #3;
        n_checks++; if ({b4_q, b4_v, b4_e, b4_c} !== 42'd0) begin n_fail++; $display("FAIL reset_b4: got q=%h v=%b e=%b c=%0d, want all 0", b4_q, b4_v, b4_e, b4_c); end
        n_checks++; if ({b3_q, b3_v, b3_e, b3_c} !== 42'd0) begin n_fail++; $display("FAIL reset_b3: got q=%h v=%b e=%b c=%0d, want all 0", b3_q, b3_v, b3_e, b3_c); end
        n_checks++; if ({oh_q, oh_v, oh_e, oh_c} !== 42'd0) begin n_fail++; $display("FAIL reset_oh: got q=%h v=%b e=%b c=%0d, want all 0", oh_q, oh_v, oh_e, oh_c); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_binary_select();
        b4_valid = 1; b4_sel = 2'd2; tick(1);
        n_checks++; if (b4_q !== 32'h22 || b4_v !== 1'b1 || b4_e !== 1'b0) begin n_fail++; $display("FAIL bin_sel2: got q=%h v=%b e=%b, want 22 1 0", b4_q, b4_v, b4_e); end
        b4_sel = 2'd3; tick(1);
        n_checks++; if (b4_q !== 32'h33 || b4_v !== 1'b1) begin n_fail++; $display("FAIL bin_sel3: got q=%h v=%b, want 33 1", b4_q, b4_v); end
        b4_sel = 2'd0; tick(1);
        n_checks++; if (b4_q !== 32'h00 || b4_v !== 1'b1) begin n_fail++; $display("FAIL bin_sel0: got q=%h v=%b, want 0 1", b4_q, b4_v); end
        b4_sel = 2'd1; tick(1);
        n_checks++; if (b4_q !== 32'h11 || b4_v !== 1'b1 || b4_c !== 8'd0) begin n_fail++; $display("FAIL bin_sel1: got q=%h v=%b c=%0d, want 11 1 0", b4_q, b4_v, b4_c); end
        b4_valid = 0; b4_sel = 2'd3; tick(1);
        n_checks++; if (b4_q !== 32'h11 || b4_v !== 1'b0 || b4_e !== 1'b0) begin n_fail++; $display("FAIL bin_idle_hold: got q=%h v=%b e=%b, want 11 0 0", b4_q, b4_v, b4_e); end
    endtask

    task automatic test_binary_illegal();
        b3_valid = 1; b3_sel = 2'd3; tick(1);
        n_checks++; if (b3_q !== 32'hDEAD || b3_v !== 1'b1 || b3_e !== 1'b1 || b3_c !== 8'd1) begin n_fail++; $display("FAIL bin3_illegal: got q=%h v=%b e=%b c=%0d, want dead 1 1 1", b3_q, b3_v, b3_e, b3_c); end
        b3_sel = 2'd2; tick(1);
        n_checks++; if (b3_q !== 32'h22 || b3_e !== 1'b0 || b3_c !== 8'd1) begin n_fail++; $display("FAIL bin3_legal: got q=%h e=%b c=%0d, want 22 0 1", b3_q, b3_e, b3_c); end
        b3_valid = 0;
    endtask

    task automatic test_onehot();
        oh_valid = 1; oh_sel = 4'b0100; tick(1);
        n_checks++; if (oh_q !== 32'h22 || oh_v !== 1'b1 || oh_e !== 1'b0) begin n_fail++; $display("FAIL oh_0100: got q=%h v=%b e=%b, want 22 1 0", oh_q, oh_v, oh_e); end
        oh_sel = 4'b0110; tick(1);
        n_checks++; if (oh_q !== 32'hBEEF || oh_e !== 1'b1 || oh_c !== 8'd1) begin n_fail++; $display("FAIL oh_0110: got q=%h e=%b c=%0d, want beef 1 1", oh_q, oh_e, oh_c); end
        oh_sel = 4'b0000; tick(1);
        n_checks++; if (oh_q !== 32'hBEEF || oh_e !== 1'b1 || oh_c !== 8'd2) begin n_fail++; $display("FAIL oh_0000: got q=%h e=%b c=%0d, want beef 1 2", oh_q, oh_e, oh_c); end
        oh_sel = 4'b1000; tick(1);
        n_checks++; if (oh_q !== 32'h33 || oh_e !== 1'b0 || oh_c !== 8'd2) begin n_fail++; $display("FAIL oh_1000: got q=%h e=%b c=%0d, want 33 0 2", oh_q, oh_e, oh_c); end
        oh_valid = 0;
    endtask

    task automatic test_stall_flush();
        b4_valid = 1; b4_sel = 2'd1; tick(1);
        n_checks++; if (b4_q !== 32'h11 || b4_v !== 1'b1) begin n_fail++; $display("FAIL stall_load: got q=%h v=%b, want 11 1", b4_q, b4_v); end
        b4_stall = 1;
        for (int i = 0; i < 3; i++) begin
            b4_sel  = 2'(i + 2);
            b4_data = {32'hA3 + 32'(i), 32'hA2, 32'hA1 + 32'(i), 32'hA0};
            tick(1);
            n_checks++; if (b4_q !== 32'h11 || b4_v !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d: got q=%h v=%b, want 11 1", i, b4_q, b4_v); end
        end
        b4_flush = 1; tick(1);
        n_checks++; if (b4_q !== 32'h0 || b4_v !== 1'b0 || b4_e !== 1'b0) begin n_fail++; $display("FAIL stall_flush: got q=%h v=%b e=%b, want 0 0 0", b4_q, b4_v, b4_e); end
        b4_stall = 0; b4_flush = 0; b4_valid = 0;
        b4_data = {32'h33, 32'h22, 32'h11, 32'h00};
        // illegal words must not bump the counter while flushed or stalled
        b3_valid = 1; b3_sel = 2'd3; b3_flush = 1; tick(1);
        n_checks++; if (b3_c !== 8'd1 || b3_v !== 1'b0 || b3_q !== 32'h0 || b3_e !== 1'b0) begin n_fail++; $display("FAIL flush_illegal: got q=%h v=%b e=%b c=%0d, want 0 0 0 1", b3_q, b3_v, b3_e, b3_c); end
        b3_flush = 0; b3_stall = 1; tick(1);
        n_checks++; if (b3_c !== 8'd1 || b3_v !== 1'b0 || b3_q !== 32'h0) begin n_fail++; $display("FAIL stall_illegal: got q=%h v=%b c=%0d, want 0 0 1", b3_q, b3_v, b3_c); end
        b3_stall = 0; b3_valid = 0;
    endtask

    task automatic test_saturation();
        b3_valid = 1; b3_sel = 2'd3;
        for (int i = 0; i < 300; i++) tick(0);
        $display("t=%0t b3 after 300 illegal selects c=%0d", $time, b3_c);
        n_checks++; if (b3_c !== 8'd255 || b3_e !== 1'b1 || b3_q !== 32'hDEAD) begin n_fail++; $display("FAIL sat_count: got c=%0d e=%b q=%h, want 255 1 dead", b3_c, b3_e, b3_q); end
        b3_valid = 0; tick(1);
        n_checks++; if (b3_c !== 8'd255 || b3_v !== 1'b0 || b3_e !== 1'b0 || b3_q !== 32'hDEAD) begin n_fail++; $display("FAIL sat_idle: got c=%0d v=%b e=%b q=%h, want 255 0 0 dead", b3_c, b3_v, b3_e, b3_q); end
    endtask

    task automatic test_async_reset();
        oh_valid = 1; oh_sel = 4'b0011;
        for (int i = 0; i < 3; i++) tick(1);
        n_checks++; if (oh_c !== 8'd5 || oh_v !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got c=%0d v=%b, want 5 1", oh_c, oh_v); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({oh_q, oh_v, oh_e, oh_c} !== 42'd0) begin n_fail++; $display("FAIL async_reset_oh: got q=%h v=%b e=%b c=%0d, want all 0", oh_q, oh_v, oh_e, oh_c); end
        n_checks++; if (b3_c !== 8'd0 || b3_q !== 32'h0) begin n_fail++; $display("FAIL async_reset_b3: got q=%h c=%0d, want 0 0", b3_q, b3_c); end
        #1;
        rst_n = 1'b1;
        oh_sel = 4'b1000; tick(1);
        n_checks++; if (oh_q !== 32'h33 || oh_v !== 1'b1 || oh_e !== 1'b0 || oh_c !== 8'd0) begin n_fail++; $display("FAIL post_reset_load: got q=%h v=%b e=%b c=%0d, want 33 1 0 0", oh_q, oh_v, oh_e, oh_c); end
        oh_valid = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_binary_select();
        test_binary_illegal();
        test_onehot();
        test_stall_flush();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
